// File: rtl/common_pkg.sv
// Shared cbus types: request/response payloads, size/length/burst encodings,
// and the arbiter state encoding.
package common;

    typedef enum logic [2:0] {
        MSIZE1 = 3'd0,
        MSIZE2 = 3'd1,
        MSIZE4 = 3'd2,
        MSIZE8 = 3'd3
    } msize_t;

    // Encoded as beats-1, matching AXI AxLEN.
    typedef enum logic [7:0] {
        MLEN1   = 8'd0,
        MLEN2   = 8'd1,
        MLEN4   = 8'd3,
        MLEN8   = 8'd7,
        MLEN16  = 8'd15,
        MLEN256 = 8'd255
    } mlen_t;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'b00,
        BURST_INCR  = 2'b01
    } burst_t;

    typedef logic [63:0] addr_t;
    typedef logic [63:0] word_t;
    typedef logic [7:0]  strobe_t;

    typedef struct packed {
        logic    valid;
        logic    is_write;
        msize_t  size;
        addr_t   addr;
        strobe_t strobe;
        word_t   data;
        mlen_t   len;
        burst_t  burst;
    } cbus_req_t;

    typedef struct packed {
        logic  ready;
        logic  last;
        word_t data;
    } cbus_resp_t;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

endpackage

// File: rtl/cbus_arbiter_rr_pick.sv
// Round-robin picker: first set bit of valid, scanning upward from
// last_sel+1 with wrap-around. Purely combinational.
module rr_pick #(
    parameter int N = 2
) (
    input  logic [N-1:0]         valid,
    input  logic [$clog2(N)-1:0] last_sel,
    output logic                 any,
    output logic [$clog2(N)-1:0] pick
);

    localparam int IDX_W = $clog2(N);
    localparam logic [IDX_W:0] ONE  = (IDX_W+1)'(1);
    localparam logic [IDX_W:0] N_WD = (IDX_W+1)'(N);

    logic [2*N-1:0] doubled;
    logic [2*N-1:0] rotated;
    logic [IDX_W:0] start;
    logic [IDX_W:0] offset;
    logic [IDX_W:0] sum;

    // Rotate the doubled vector so the scan start lands at bit 0, then
    // priority-encode the lowest set bit and map it back to a master index.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        offset  = '0;
        start   = {1'b0, last_sel} + ONE;
        doubled = {valid, valid};
        rotated = doubled >> start;
        for (int i = N - 1; i >= 0; i--) begin
            if (rotated[i]) begin
                offset = (IDX_W+1)'(i);
            end
        end
        // start <= N and offset <= N-1, so one subtraction finishes the wrap.
        sum = start + offset;
        if (sum >= N_WD) begin
            sum = sum - N_WD;
        end
        any  = |valid;
        pick = sum[IDX_W-1:0];
    end

endmodule

// File: rtl/cbus_arbiter.sv
// Merges NUM_MASTERS cbus ports into one. The grant is held for a whole
// burst; payloads pass straight through so per-beat write data is never stale.
module cbus_arbiter
    import common::*;
#(
    parameter int NUM_MASTERS = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  cbus_req_t  ireqs  [NUM_MASTERS],
    output cbus_resp_t iresps [NUM_MASTERS],
    output cbus_req_t  oreq,
    input  cbus_resp_t oresp
);

    localparam int IDX_W = $clog2(NUM_MASTERS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_MASTERS - 1);

    arb_state_t             state;
    logic [IDX_W-1:0]       sel;
    logic [IDX_W-1:0]       last_sel;
    logic [NUM_MASTERS-1:0] valid_vec;
    logic                   any_valid;
    logic [IDX_W-1:0]       pick;

    // Gather the request valids into a vector for the picker.
    always_comb begin
        for (int i = 0; i < NUM_MASTERS; i++) begin
            valid_vec[i] = ireqs[i].valid;
        end
    end

    rr_pick #(
        .N(NUM_MASTERS)
    ) u_rr_pick (
        .valid    (valid_vec),
        .last_sel (last_sel),
        .any      (any_valid),
        .pick     (pick)
    );

    // Grant FSM: latch a winner in IDLE, hold it until the bridge's last beat.
    always_ff @(posedge clk) begin
        // NOTE: state registers use <= so every branch sees the pre-edge values.
        if (reset) begin
            state    <= IDLE;
            sel      <= '0;
            last_sel <= LAST_IDX;
        end else begin
            case (state)
                IDLE: begin
                    if (any_valid) begin
                        sel      <= pick;
                        last_sel <= pick;
                        state    <= BUSY;
                    end
                end
                BUSY: begin
                    // The grant survives a dropped valid; only last ends it.
                    if (oresp.ready && oresp.last) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Route the granted master to the bridge and the bridge's response back.
    always_comb begin
        oreq = '0;
        if (state == BUSY) begin
            oreq = ireqs[sel];
        end
        for (int i = 0; i < NUM_MASTERS; i++) begin
            iresps[i] = '0;
            if (state == BUSY && sel == IDX_W'(i)) begin
                iresps[i] = oresp;
            end
        end
    end

endmodule
